uart_rx_core: RTL and testbench

//  Serial-to-parallel UART receiver; the receive end of the TB/DUT UART link
//  (drives rx_valid, frame_error, parity_error from the serial rx line).

---
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_rx_core.sv | 94 +++++++++
 tb/tb_uart_rx_core.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, configuration and received-frame outputs of the UART receiver
interface uart_rx_if #(parameter int DATA_BITS = 8);
  logic                 rx;
  logic                 parity_en;
  logic [12:0]          clk_per_bit;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_error;
  logic                 parity_error;
  modport master (output rx, parity_en, clk_per_bit, input rx_data, rx_valid, frame_error, parity_error);
  modport slave  (input rx, parity_en, clk_per_bit, output rx_data, rx_valid, frame_error, parity_error);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver, centre-sampled LSB-first frames with optional parity
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input logic     clk,
  input logic     rst_n,
  uart_rx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_d, fall;
  logic [12:0]            n_q, n_in, cnt_q, target;
  logic [3:0]             bit_cnt_q;
  logic [DATA_BITS-1:0]   shreg_q, data_q;
  logic                   par_en_q, pbit_q, tick, last_bit;
  logic                   done, pe_d;
  logic                   valid_q, fe_q, pe_q;
  assign rxs      = sync_q[SYNC_STAGES-1];
  assign fall     = rxs_d & ~rxs;
  assign n_in     = (bus.clk_per_bit < 13'd4) ? 13'd4 : bus.clk_per_bit;
  assign target   = (state_q == START) ? {1'b0, n_q[12:1]} - 13'd1 : n_q - 13'd1;
  assign tick     = cnt_q == target;
  assign last_bit = bit_cnt_q == 4'(DATA_BITS - 1);
  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.frame_error  = fe_q;
  assign bus.parity_error = pe_q;
  // metastability synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
      rxs_d  <= rxs;
    end
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // next-state logic: a start sample reading 1 is a glitch and drops back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fall ? START : IDLE;
      START:   state_d = tick ? (rxs ? IDLE : DATA) : START;
      DATA:    state_d = (tick && last_bit) ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_d = tick ? STOP : PARITY;
      STOP:    state_d = tick ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // frame completion and its error flags, decided at the mid-stop sample
  always_comb begin
    done = (state_q == STOP) && tick;
    pe_d = par_en_q && ((^shreg_q ^ pbit_q) != 1'(PARITY_ODD));
  end
  // datapath: bit timer, shift register, latched config and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q       <= '0;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      pbit_q    <= 1'b0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      cnt_q <= (state_q == IDLE || tick) ? '0 : cnt_q + 13'd1;
      if (state_q == IDLE && fall) begin
        n_q       <= n_in;
        par_en_q  <= bus.parity_en;
        bit_cnt_q <= '0;
      end
      if (state_q == DATA && tick) begin
        shreg_q   <= {rxs, shreg_q[DATA_BITS-1:1]};
        bit_cnt_q <= bit_cnt_q + 4'd1;
      end
      if (state_q == PARITY && tick) pbit_q <= rxs;
      if (done) data_q <= shreg_q;
      valid_q <= done;
      fe_q    <= done & ~rxs;
      pe_q    <= done & pe_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames with hand-computed results for the UART receiver
module tb_uart_rx_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   t_start = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   flag_err = 0;
  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         cyc;
  } rec_t;
  rec_t q[$];
  uart_rx_if #(.DATA_BITS(8)) bus ();
  uart_rx_core #(.DATA_BITS(8), .SYNC_STAGES(2), .PARITY_ODD(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // record every cycle rx_valid is high; flags outside a pulse are errors
  always @(negedge clk) begin
    if (bus.rx_valid) q.push_back('{bus.rx_data, bus.frame_error, bus.parity_error, cyc});
    else if (bus.frame_error || bus.parity_error) flag_err++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int k);
    bus.rx = 1'b1;
    repeat (k) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic pen, input logic pb, input logic stop, input int n);
    bus.rx  = 1'b0;
    t_start = cyc;
    repeat (n) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (n) @(negedge clk);
    end
    if (pen) begin
      bus.rx = pb;
      repeat (n) @(negedge clk);
    end
    bus.rx = stop;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int lat;
    bus.rx = 1'b1;
    bus.parity_en = 1'b0;
    bus.clk_per_bit = 13'd16;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(bus.rx_data), 32'h0);
    chk("rst_valid", 32'(bus.rx_valid), 32'h0);
    chk("rst_fe", 32'(bus.frame_error), 32'h0);
    chk("rst_pe", 32'(bus.parity_error), 32'h0);
    rst_n = 1'b1;
    idle(10);
    // 0xA5, N=16, clk_per_bit disturbed mid-frame must be ignored
    fork
      send(8'hA5, 1'b0, 1'b0, 1'b1, 16);
      begin
        repeat (50) @(negedge clk);
        bus.clk_per_bit = 13'd5;
      end
    join
    bus.clk_per_bit = 13'd16;
    idle(20);
    chk("a5_count", 32'(q.size()), 32'd1);
    if (q.size() > 0) begin
      lat = q[0].cyc - t_start - 2;
      chk("a5_data", 32'(q[0].d), 32'hA5);
      chk("a5_fe", 32'(q[0].fe), 32'h0);
      chk("a5_pe", 32'(q[0].pe), 32'h0);
      chk("a5_latency_in_151_153", 32'(lat >= 151 && lat <= 153), 32'd1);
    end
    q.delete();
    // even parity: 0x3C has four ones, so pbit=0 is correct and pbit=1 is wrong
    bus.parity_en = 1'b1;
    send(8'h3C, 1'b1, 1'b0, 1'b1, 16);
    idle(20);
    send(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    idle(20);
    bus.parity_en = 1'b0;
    chk("par_count", 32'(q.size()), 32'd2);
    if (q.size() == 2) begin
      chk("par_ok_pe", 32'(q[0].pe), 32'h0);
      chk("par_ok_data", 32'(q[0].d), 32'h3C);
      chk("par_bad_pe", 32'(q[1].pe), 32'h1);
      chk("par_bad_data", 32'(q[1].d), 32'h3C);
      chk("par_bad_fe", 32'(q[1].fe), 32'h0);
    end
    q.delete();
    // stop bit 0 then break: one errored frame only
    send(8'h55, 1'b0, 1'b0, 1'b0, 16);
    repeat (200) @(negedge clk);
    chk("brk_count", 32'(q.size()), 32'd1);
    if (q.size() > 0) begin
      chk("brk_fe", 32'(q[0].fe), 32'h1);
      chk("brk_data", 32'(q[0].d), 32'h55);
    end
    q.delete();
    idle(40);
    // 3-cycle glitch, then a real frame
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(60);
    chk("glitch_count", 32'(q.size()), 32'd0);
    send(8'h0F, 1'b0, 1'b0, 1'b1, 16);
    idle(20);
    chk("post_glitch_count", 32'(q.size()), 32'd1);
    if (q.size() > 0) chk("post_glitch_data", 32'(q[0].d), 32'h0F);
    q.delete();
    // reset during data bit 4 of 0xFF
    bus.rx = 1'b0;
    repeat (16) @(negedge clk);
    bus.rx = 1'b1;
    repeat (16 * 4 + 8) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_data", 32'(bus.rx_data), 32'h0);
    chk("midrst_valid", 32'(bus.rx_valid), 32'h0);
    rst_n = 1'b1;
    idle(200);
    chk("midrst_nopulse", 32'(q.size()), 32'd0);
    send(8'h81, 1'b0, 1'b0, 1'b1, 16);
    idle(20);
    chk("after_rst_count", 32'(q.size()), 32'd1);
    if (q.size() > 0) chk("after_rst_data", 32'(q[0].d), 32'h81);
    q.delete();
    // back-to-back at N=5 with one-bit stop
    bus.clk_per_bit = 13'd5;
    send(8'h12, 1'b0, 1'b0, 1'b1, 5);
    send(8'h34, 1'b0, 1'b0, 1'b1, 5);
    idle(20);
    chk("b2b_count", 32'(q.size()), 32'd2);
    if (q.size() == 2) begin
      chk("b2b_data0", 32'(q[0].d), 32'h12);
      chk("b2b_data1", 32'(q[1].d), 32'h34);
      chk("b2b_err", 32'({q[0].fe, q[0].pe, q[1].fe, q[1].pe}), 32'h0);
    end
    q.delete();
    // clk_per_bit below 4 runs at 4 cycles per bit
    bus.clk_per_bit = 13'd2;
    send(8'h6B, 1'b0, 1'b0, 1'b1, 4);
    idle(20);
    chk("nmin_count", 32'(q.size()), 32'd1);
    if (q.size() > 0) chk("nmin_data", 32'(q[0].d), 32'h6B);
    q.delete();
    chk("flags_outside_pulse", 32'(flag_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
